// File: rtl/dkong3_obj_dma.sv
// -----------------------------------------------------------------------------
// dkong3_obj_dma
// Sprite-table DMA writer. A rising edge on I_START requests the Z80 bus,
// copies DMA_LEN bytes from CPU work RAM (starting at I_SRC_BASE) into the
// object RAM DMA port (bank I_BANK), then releases the bus. Two clocks per byte.
//
// Ports:
//   I_CLK_12M      system clock, rising edge
//   RST_4L         asynchronous active-low reset
//   I_START        transfer trigger (rising edge, accepted only when idle)
//   I_SRC_BASE     source start address, latched at start
//   I_BANK         destination bank (object RAM address bit 9), latched at start
//   O_BUSRQn       Z80 bus request, active-low
//   I_BUSAKn       Z80 bus acknowledge, active-low
//   O_CPU_A        source read address (base + index, wraps)
//   O_CPU_RDn      source read strobe, active-low
//   I_CPU_D        source read data, valid while O_CPU_RDn is low
//   O_OBJ_DMA_A    object RAM write address {bank, index[8:0]}
//   O_OBJ_DMA_D    object RAM write data
//   O_OBJ_DMA_CE   object RAM write enable, one cycle per byte
//   O_BUSY         high from start detection until return to idle
//   O_DONE         one-cycle completion pulse
// -----------------------------------------------------------------------------
module dkong3_obj_dma #(
    parameter int DMA_LEN = 384,
    parameter int SRC_W   = 16
) (
    input  logic             I_CLK_12M,
    input  logic             RST_4L,
    input  logic             I_START,
    input  logic [SRC_W-1:0] I_SRC_BASE,
    input  logic             I_BANK,
    output logic             O_BUSRQn,
    input  logic             I_BUSAKn,
    output logic [SRC_W-1:0] O_CPU_A,
    output logic             O_CPU_RDn,
    input  logic [7:0]       I_CPU_D,
    output logic [9:0]       O_OBJ_DMA_A,
    output logic [7:0]       O_OBJ_DMA_D,
    output logic             O_OBJ_DMA_CE,
    output logic             O_BUSY,
    output logic             O_DONE
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_RD   = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_REL  = 3'd4;

    localparam logic [9:0] LAST_IDX = 10'(DMA_LEN - 1);

    logic [2:0]       state;
    logic             start_q;
    logic             start;
    logic [SRC_W-1:0] base;
    logic             bank;
    logic [9:0]       index;
    logic [9:0]       obj_a;
    logic [7:0]       obj_d;
    logic             done;

    assign start = I_START & ~start_q;

    always_ff @(posedge I_CLK_12M or negedge RST_4L) begin
        if (!RST_4L) begin
            state   <= ST_IDLE;
            start_q <= 1'b0;
            base    <= '0;
            bank    <= 1'b0;
            index   <= '0;
            obj_a   <= '0;
            obj_d   <= '0;
            done    <= 1'b0;
        end else begin
            start_q <= I_START;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Edges arriving in any other state are dropped, not queued.
                    if (start) begin
                        base  <= I_SRC_BASE;
                        bank  <= I_BANK;
                        index <= '0;
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!I_BUSAKn) state <= ST_RD;
                end
                ST_RD: begin
                    // Losing BUSAK mid-transfer stalls here without writing.
                    if (!I_BUSAKn) begin
                        obj_d <= I_CPU_D;
                        obj_a <= {bank, index[8:0]};
                        state <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (index == LAST_IDX) begin
                        state <= ST_REL;
                    end else begin
                        index <= index + 10'd1;
                        state <= ST_RD;
                    end
                end
                ST_REL: begin
                    if (I_BUSAKn) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Source address wraps naturally at 2^SRC_W.
    assign O_CPU_A      = base + SRC_W'(index);
    assign O_CPU_RDn    = ~((state == ST_RD) & ~I_BUSAKn);
    assign O_BUSRQn     = ~((state == ST_REQ) | (state == ST_RD) | (state == ST_WR));
    assign O_OBJ_DMA_A  = obj_a;
    assign O_OBJ_DMA_D  = obj_d;
    assign O_OBJ_DMA_CE = (state == ST_WR);
    assign O_BUSY       = (state != ST_IDLE);
    assign O_DONE       = done;

endmodule

// File: tb/tb_dkong3_obj_dma.sv
// -----------------------------------------------------------------------------
// tb_dkong3_obj_dma
// Randomized self-checking bench for dkong3_obj_dma. A 64 KiB random source
// RAM feeds the DUT; a simple Z80 bus model acknowledges BUSRQn half a cycle
// later. Every observed object-RAM write is compared against the expected
// copy computed directly from the source RAM contents.
// -----------------------------------------------------------------------------
module tb_dkong3_obj_dma;

    localparam int LEN      = 384;
    localparam int MIN_BUSY = 2 * LEN + 2;
    localparam int BUDGET   = 4000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] src_base;
    logic        bank;
    logic        busrq_n;
    logic        busak_n;
    logic [15:0] cpu_a;
    logic        cpu_rd_n;
    logic [7:0]  cpu_d;
    logic [9:0]  obj_a;
    logic [7:0]  obj_d;
    logic        obj_ce;
    logic        busy;
    logic        done;

    logic [7:0]  ram [0:65535];

    int total = 0;
    int bad   = 0;

    // monitor records
    int          ce_n, busy_n, done_n, rd_viol;
    logic [9:0]  ce_a [0:511];
    logic [7:0]  ce_d [0:511];
    logic        pause;

    dkong3_obj_dma #(.DMA_LEN(LEN), .SRC_W(16)) dut (
        .I_CLK_12M   (clk),
        .RST_4L      (rst_n),
        .I_START     (start),
        .I_SRC_BASE  (src_base),
        .I_BANK      (bank),
        .O_BUSRQn    (busrq_n),
        .I_BUSAKn    (busak_n),
        .O_CPU_A     (cpu_a),
        .O_CPU_RDn   (cpu_rd_n),
        .I_CPU_D     (cpu_d),
        .O_OBJ_DMA_A (obj_a),
        .O_OBJ_DMA_D (obj_d),
        .O_OBJ_DMA_CE(obj_ce),
        .O_BUSY      (busy),
        .O_DONE      (done)
    );

    assign cpu_d = ram[cpu_a];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Z80 bus model: acknowledge follows request shortly after each falling edge,
    // unless the bench forces the bus away.
    always @(negedge clk) begin
        #1;
        busak_n = pause ? 1'b1 : busrq_n;
    end

    always @(posedge clk) begin
        #1;
        if (obj_ce) begin
            if (ce_n < 512) begin
                ce_a[ce_n] = obj_a;
                ce_d[ce_n] = obj_d;
            end
            ce_n++;
        end
        if (busy) busy_n++;
        if (done) done_n++;
        if (busak_n && !cpu_rd_n) rd_viol++;
    end

    task automatic clear_mon();
        ce_n = 0; busy_n = 0; done_n = 0; rd_viol = 0;
    endtask

    // Reference: byte n lands at {bank, n} holding ram[(base + n) mod 2^16].
    function automatic int count_bad(input logic [15:0] b, input logic bk, output int first);
        int nb = 0;
        logic [15:0] sa;
        logic [9:0]  ea;
        first = -1;
        for (int n = 0; n < LEN; n++) begin
            sa = b + 16'(n);
            ea = {bk, 9'(n)};
            if (n >= ce_n || ce_a[n] !== ea || ce_d[n] !== ram[sa]) begin
                if (first < 0) first = n;
                nb++;
            end
        end
        return nb;
    endfunction

    task automatic fill_ram();
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    endtask

    task automatic kick(input logic [15:0] b, input logic bk);
        @(negedge clk);
        src_base = b;
        bank     = bk;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (done_n > 0) begin ok = 1'b1; break; end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; src_base = '0; bank = 1'b0; pause = 1'b0; busak_n = 1'b1;
        clear_mon();
        repeat (3) @(negedge clk);
        total++; if (busrq_n !== 1'b1) begin bad++; $display("FAIL reset_busrq got=%b exp=1", busrq_n); end
        total++; if (cpu_rd_n !== 1'b1) begin bad++; $display("FAIL reset_rdn got=%b exp=1", cpu_rd_n); end
        total++; if (cpu_a !== 16'h0000) begin bad++; $display("FAIL reset_cpu_a got=%h exp=0000", cpu_a); end
        total++; if (obj_a !== 10'h000 || obj_d !== 8'h00) begin bad++; $display("FAIL reset_obj got=%h/%h exp=000/00", obj_a, obj_d); end
        total++; if ({obj_ce, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {obj_ce, busy, done}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_plain(input string name, input logic [15:0] b, input logic bk);
        bit ok;
        int first, nb;
        clear_mon();
        kick(b, bk);
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL %s_timeout no DONE within %0d cycles", name, BUDGET); end
        total++; if (ce_n !== LEN) begin bad++; $display("FAIL %s_ce_count got=%0d exp=%0d", name, ce_n, LEN); end
        nb = count_bad(b, bk, first);
        total++; if (nb !== 0) begin bad++; $display("FAIL %s_data bad_bytes=%0d first=%0d exp=0", name, nb, first); end
        total++; if (done_n !== 1) begin bad++; $display("FAIL %s_done got=%0d exp=1", name, done_n); end
        total++; if (busy_n !== MIN_BUSY) begin bad++; $display("FAIL %s_busy got=%0d exp=%0d", name, busy_n, MIN_BUSY); end
    endtask

    task automatic test_basic();
        run_plain("basic", 16'($urandom_range(16'h0000, 16'hF000)), 1'b0);
    endtask

    task automatic test_bank1();
        run_plain("bank1", 16'($urandom_range(16'h0000, 16'hF000)), 1'b1);
    endtask

    task automatic test_wrap();
        run_plain("wrap", 16'hFF80 + 16'($urandom_range(0, 127)), 1'($urandom));
    endtask

    task automatic test_pause();
        bit ok;
        int first, nb;
        logic [15:0] b = 16'($urandom);
        clear_mon();
        kick(b, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (ce_n == 100) begin ok = 1'b1; break; end
        end
        pause = 1'b1;
        repeat (5) @(negedge clk);
        pause = 1'b0;
        total++; if (ce_n !== 100) begin bad++; $display("FAIL pause_no_ce got=%0d exp=100", ce_n); end
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL pause_timeout no DONE within %0d cycles", BUDGET); end
        total++; if (rd_viol !== 0) begin bad++; $display("FAIL pause_rdn low_while_released=%0d exp=0", rd_viol); end
        total++; if (ce_n !== LEN) begin bad++; $display("FAIL pause_ce_count got=%0d exp=%0d", ce_n, LEN); end
        nb = count_bad(b, 1'b0, first);
        total++; if (nb !== 0) begin bad++; $display("FAIL pause_data bad_bytes=%0d first=%0d exp=0", nb, first); end
        // four extra read cycles while the bus is away
        total++; if (busy_n !== MIN_BUSY + 4) begin bad++; $display("FAIL pause_busy got=%0d exp=%0d", busy_n, MIN_BUSY + 4); end
    endtask

    task automatic test_retrigger();
        bit ok;
        int first, nb;
        logic [15:0] b = 16'($urandom);
        clear_mon();
        kick(b, 1'b1);
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (ce_n == 50) break;
        end
        src_base = ~b;
        bank     = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL retrig_timeout no DONE within %0d cycles", BUDGET); end
        total++; if (ce_n !== LEN) begin bad++; $display("FAIL retrig_ce_count got=%0d exp=%0d", ce_n, LEN); end
        nb = count_bad(b, 1'b1, first);
        total++; if (nb !== 0) begin bad++; $display("FAIL retrig_data bad_bytes=%0d first=%0d exp=0", nb, first); end
        total++; if (done_n !== 1) begin bad++; $display("FAIL retrig_done got=%0d exp=1", done_n); end
        total++; if (busy_n !== MIN_BUSY) begin bad++; $display("FAIL retrig_busy got=%0d exp=%0d", busy_n, MIN_BUSY); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        kick(16'($urandom), 1'b0);
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (ce_n == 200) break;
        end
        #2 rst_n = 1'b0;
        #1;
        total++; if (busrq_n !== 1'b1) begin bad++; $display("FAIL rstmid_busrq got=%b exp=1", busrq_n); end
        total++; if (obj_ce !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_ce_busy got=%b%b exp=00", obj_ce, busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (done_n !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", done_n); end
        run_plain("after_rst", 16'($urandom), 1'b0);
    endtask

    task automatic test_start_at_rel();
        bit seen = 1'b0;
        clear_mon();
        kick(16'($urandom), 1'b0);
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (busy && busrq_n) begin seen = 1'b1; break; end
        end
        total++; if (!seen) begin bad++; $display("FAIL simul_rel_timeout REL not reached within %0d cycles", BUDGET); end
        start = 1'b1;
        @(negedge clk);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL simul_done got=done%b busy%b exp=done1 busy0", done, busy); end
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0 || busrq_n !== 1'b1) begin bad++; $display("FAIL simul_ignored got=busy%b busrq%b exp=busy0 busrq1", busy, busrq_n); end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        fill_ram();
        test_reset();
        test_basic();
        test_bank1();
        test_wrap();
        test_pause();
        test_retrigger();
        test_reset_mid();
        test_start_at_rel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dkong3_obj_dma.md
# dkong3_obj_dma

Sprite-table DMA writer for the Donkey Kong 3 core. On a CPU trigger it requests the Z80 bus, copies a block of sprite attribute bytes from CPU work RAM into the dual-port object RAM, then releases the bus. Its object-RAM write port drives the DMA side (address/data/CE) that the object renderer's RAM consumes. Transfer is 2 clocks per byte.

## Interface
Parameters:
- DMA_LEN, 384, bytes per transfer; legal range 1..512.
- SRC_W, 16, CPU address width.

Ports:
- I_CLK_12M  in  1  system clock; all logic on rising edge.
- RST_4L  in  1  reset, asynchronous, active-low.
- I_START  in  1  DMA trigger from CPU register write; rising edge starts a transfer.
- I_SRC_BASE  in  SRC_W  source start address in CPU space, latched at start.
- I_BANK  in  1  destination object-RAM bank (address bit 9), latched at start.
- O_BUSRQn  out  1  Z80 bus request, active-low.
- I_BUSAKn  in  1  Z80 bus acknowledge, active-low.
- O_CPU_A  out  SRC_W  source read address.
- O_CPU_RDn  out  1  source read strobe, active-low.
- I_CPU_D  in  8  source read data, valid in the same cycle O_CPU_RDn is low.
- O_OBJ_DMA_A  out  10  object-RAM write address {bank, index[8:0]}.
- O_OBJ_DMA_D  out  8  object-RAM write data.
- O_OBJ_DMA_CE  out  1  object-RAM write enable, one cycle per byte.
- O_BUSY  out  1  high from start detection until return to IDLE.
- O_DONE  out  1  one-cycle pulse on transfer completion.

## Operation
- Start detect: I_START registered; start = I_START & ~start_q. Accepted only in IDLE; edges in any other state are ignored, not queued.
- States: IDLE, REQ, RD, WR, REL.
- IDLE: all strobes inactive. On start: latch I_SRC_BASE, I_BANK; clear index; go REQ.
- REQ: O_BUSRQn=0. I_BUSAKn sampled low -> RD.
- RD: O_CPU_A = base + index (mod 2^SRC_W), O_CPU_RDn=0. If I_BUSAKn high: O_CPU_RDn=1, stay RD (pause, no write). Else at clock edge register O_OBJ_DMA_D <= I_CPU_D, O_OBJ_DMA_A <= {bank, index[8:0]}, go WR.
- WR: O_OBJ_DMA_CE=1 for exactly this cycle; O_CPU_RDn=1. If index == DMA_LEN-1 -> REL, else index+1 -> RD.
- REL: O_BUSRQn=1. I_BUSAKn sampled high -> IDLE with O_DONE=1 for one cycle.
- Index width 10 bits; destination low 9 bits never exceed 511 (DMA_LEN <= 512); source address wraps 0xFFFF -> 0x0000.
- O_OBJ_DMA_A/D hold last value outside WR; only CE qualifies writes.

## Timing
- Reset values: O_BUSRQn=1, O_CPU_RDn=1, O_CPU_A=0, O_OBJ_DMA_A=0, O_OBJ_DMA_D=0, O_OBJ_DMA_CE=0, O_BUSY=0, O_DONE=0, state IDLE. Reset mid-transfer returns to these immediately (async); no partial completion, no DONE.
- I_START low at edge k-1, high at edge k: REQ and O_BUSY=1, O_BUSRQn=0 after edge k.
- BUSAKn low sampled at edge m: RD cycle after m; first CE cycle after m+1.
- Steady state: CE every second cycle; byte n written in cycle after edge m+2n+1.
- Last CE followed by REL; O_BUSRQn rises the cycle after last CE.
- BUSAKn high sampled at edge r in REL: O_DONE high and O_BUSY low for cycle after r.
- Minimum total, BUSAKn immediate: 1 (REQ) + 2*DMA_LEN + 1 (REL) cycles from start detect to DONE.
- Simultaneous start edge and REL completion: start ignored.

## Test plan
- Basic: DMA_LEN=384, base 0x6900, bank 0, RAM[0x6900+i]=i^0x5A, BUSAKn 1 cycle after BUSRQn -> 384 CE pulses, A=0..383, D=i^0x5A, DONE once, BUSY 770 cycles.
- Bank 1: same with I_BANK=1 -> addresses 0x200..0x37F.
- Bus pause: drop BUSAKn high for 5 cycles during byte 100 -> no CE, RDn high during pause, byte 100 written correctly afterward, total 384 CEs.
- Wrap: base 0xFFF0, DMA_LEN=32 -> O_CPU_A 0xFFF0..0xFFFF then 0x0000..0x000F.
- Retrigger: second I_START edge at byte 50 -> ignored, exactly 384 CEs, single DONE.
- Reset at byte 200: RST_4L low -> BUSRQn=1, CE=0, BUSY=0 asynchronously; next start restarts at index 0.
